// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: load-mask bit positions, exception
// vector bit positions, MEM FSM state encoding and a mask helper.
package mem_wb_stage_pkg;

  // One-hot load-type mask bit positions
  localparam int L_LB  = 0;
  localparam int L_LH  = 1;
  localparam int L_LW  = 2;
  localparam int L_LBU = 3;
  localparam int L_LHU = 4;

  // Exception vector bit positions; EXC_LMISAL is added by the MEM stage
  localparam int EXC_EXP     = 0;
  localparam int EXC_INT     = 1;
  localparam int EXC_IAMISAL = 2;
  localparam int EXC_ILLG    = 3;
  localparam int EXC_ECALL   = 4;
  localparam int EXC_EBREAK  = 5;
  localparam int EXC_LMISAL  = 6;

  typedef enum logic [1:0] {
    MEM_RUN   = 2'd0,
    MEM_HOLD  = 2'd1,
    MEM_DRAIN = 2'd2
  } mem_state_e;

  // A load mask is only honoured when exactly one type bit is set
  function automatic logic l_mask_onehot(input logic [4:0] m);
    return $onehot(m);
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Load data extraction: shifts the read word down to the addressed byte/half
// and sign- or zero-extends it according to the one-hot load mask.
module mem_load_align
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata,
  input  logic [1:0]      addr_2low,
  input  logic [4:0]      l_mask,
  output logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {addr_2low, 3'b000};

  // Select and extend the addressed field; a bad mask passes the raw word
  always_comb begin
    wdata = rdata;
    if (l_mask_onehot(l_mask)) begin
      if (l_mask[L_LB])
        wdata = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      else if (l_mask[L_LH])
        wdata = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      else if (l_mask[L_LW])
        wdata = shifted;
      else if (l_mask[L_LBU])
        wdata = {{(XLEN-8){1'b0}}, shifted[7:0]};
      else
        wdata = {{(XLEN-16){1'b0}}, shifted[15:0]};
    end
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM pipeline stage and MEM/WB register. Waits for the data-memory read
// response on loads, extracts load data, and hands the write-back payload to
// WB over the valid/allowin handshake. One outstanding load; a response
// orphaned by a flush is drained before new work is accepted.
// Optional feature: define MEM_LOAD_MISALIGN_CHECK_EN to flag misaligned
// LH/LHU/LW loads in wb_exc[6] without waiting for memory.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// MEM_RUN   | normal flow; a load waits here for dmem_rvalid
// MEM_HOLD  | response arrived while WB stalled; data parked in rbuf
// MEM_DRAIN | load flushed before its response; swallow it, block input
module mem_wb_stage
  import mem_wb_stage_pkg::*;
#(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ex_mem_valid,
  output logic                     mem_allowin,
  output logic                     mem_wb_valid,
  input  logic                     wb_allowin,
  input  logic                     flush,
  input  logic [XLEN-1:0]          mem_pc,
  input  logic [XLEN-1:0]          mem_inst,
  input  logic                     mem_req_rf,
  input  logic [RF_ADDR_WIDTH-1:0] mem_rf_waddr,
  input  logic [XLEN-1:0]          mem_alu_res,
  input  logic                     mem_is_load,
  input  logic [1:0]               mem_ls_addr_2low,
  input  logic [4:0]               mem_l_mask,
  input  logic [5:0]               mem_exc,
  input  logic                     dmem_rvalid,
  input  logic [XLEN-1:0]          dmem_rdata,
  output logic                     mem_valid,
  output logic [XLEN-1:0]          wb_pc,
  output logic [XLEN-1:0]          wb_inst,
  output logic                     wb_req_rf,
  output logic [RF_ADDR_WIDTH-1:0] wb_rf_waddr,
  output logic [XLEN-1:0]          wb_rf_wdata,
  output logic [6:0]               wb_exc
);

  mem_state_e      state;
  logic [XLEN-1:0] rbuf;
  logic            ready_go;
  logic            lmisal;
  logic            load_wait;
  logic [XLEN-1:0] load_src;
  logic [XLEN-1:0] load_data;
  logic [6:0]      exc_d;

`ifdef MEM_LOAD_MISALIGN_CHECK_EN
  assign lmisal = mem_is_load &
                  (((mem_l_mask[L_LH] | mem_l_mask[L_LHU]) & mem_ls_addr_2low[0]) |
                   (mem_l_mask[L_LW] & (mem_ls_addr_2low != 2'b00)));
`else
  assign lmisal = 1'b0;
`endif

  // A misaligned load gets no memory response, so it never waits
  assign load_wait = mem_is_load & ~lmisal;

  // Stage completes once load data is available (live or parked)
  always_comb begin
    ready_go = 1'b1;
    if (load_wait) begin
      unique case (state)
        MEM_RUN:  ready_go = dmem_rvalid;
        MEM_HOLD: ready_go = 1'b1;
        default:  ready_go = 1'b0;
      endcase
    end
  end

  assign mem_allowin  = (state != MEM_DRAIN) & (~mem_valid | (ready_go & wb_allowin));
  assign mem_wb_valid = mem_valid & ready_go & ~flush;

  assign load_src = (state == MEM_HOLD) ? rbuf : dmem_rdata;

  mem_load_align #(.XLEN(XLEN)) u_align (
    .rdata     (load_src),
    .addr_2low (mem_ls_addr_2low),
    .l_mask    (mem_l_mask),
    .wdata     (load_data)
  );

  always_comb begin
    exc_d             = {1'b0, mem_exc};
    exc_d[EXC_LMISAL] = lmisal;
  end

  // Stage occupancy: flush kills, otherwise refill when allowed
  always_ff @(posedge clk) begin
    if (!rst_n)
      mem_valid <= 1'b0;
    else if (flush)
      mem_valid <= 1'b0;
    else if (mem_allowin)
      mem_valid <= ex_mem_valid;
  end

  // Load-response FSM with the park buffer for a stalled WB
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= MEM_RUN;
      rbuf  <= '0;
    end else begin
      unique case (state)
        MEM_RUN: begin
          if (mem_valid && load_wait) begin
            if (flush) begin
              // Same-cycle response is simply dropped; otherwise wait for it
              if (!dmem_rvalid)
                state <= MEM_DRAIN;
            end else if (dmem_rvalid && !wb_allowin) begin
              state <= MEM_HOLD;
              rbuf  <= dmem_rdata;
            end
          end
        end
        MEM_HOLD: begin
          if (flush || wb_allowin)
            state <= MEM_RUN;
        end
        MEM_DRAIN: begin
          if (dmem_rvalid)
            state <= MEM_RUN;
        end
        default: state <= MEM_RUN;
      endcase
    end
  end

  // MEM/WB register: updates only on a completed handshake
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wb_pc       <= '0;
      wb_inst     <= '0;
      wb_req_rf   <= 1'b0;
      wb_rf_waddr <= '0;
      wb_rf_wdata <= '0;
      wb_exc      <= '0;
    end else if (mem_wb_valid && wb_allowin) begin
      wb_pc       <= mem_pc;
      wb_inst     <= mem_inst;
      wb_req_rf   <= mem_req_rf & ~lmisal;
      wb_rf_waddr <= mem_rf_waddr;
      wb_rf_wdata <= mem_is_load ? load_data : mem_alu_res;
      wb_exc      <= exc_d;
    end
  end

endmodule
